seconds_counter: RTL and testbench

Upstream neighbour of the stopwatch minutes counter. Divides the system clock to a 1 Hz tick and counts seconds 0..59 under a start/stop/clear control FSM. On each 59->0 wrap it drives a one-cycle `roll` that connects directly to the minutes counter's `enable` input.

---
 rtl/stopwatch_pkg.sv | 13 +
 rtl/seconds_counter_if.sv | 22 ++
 rtl/seconds_counter_tick_prescaler.sv | 30 +++
 rtl/seconds_counter.sv | 69 ++++++
 tb/tb_seconds_counter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch constants and control state type
package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

endpackage

// File: rtl/seconds_counter_if.sv
// rtl/seconds_counter_if.sv - control requests and seconds/roll/running status bundle
interface seconds_counter_if;
    import stopwatch_pkg::*;

    logic             start;
    logic             stop;
    logic             clear;
    logic [SEC_W-1:0] seconds;
    logic             roll;
    logic             running;

    modport master (
        output start, stop, clear,
        input  seconds, roll, running
    );

    modport slave (
        input  start, stop, clear,
        output seconds, roll, running
    );

endinterface

// File: rtl/seconds_counter_tick_prescaler.sv
// rtl/seconds_counter_tick_prescaler.sv - divides the system clock into a one-cycle tick
module tick_prescaler #(
    parameter int CLK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] count;

    // clr masks the tick so a clear never lets a wrap leak downstream
    assign tick = en & ~clr & (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || tick) begin
            count <= '0;
        end else if (en) begin
            count <= count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/seconds_counter.sv
// rtl/seconds_counter.sv - start/stop/clear controlled 0..59 seconds counter with roll pulse
module seconds_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_DIV = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    seconds_counter_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    logic             run_en;
    logic             tick;
    logic [SEC_W-1:0] seconds_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear beats stop, and stop beats start even where stop alone is a no-op
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, PAUSED: if (bus.start && !bus.stop) state_nxt = RUNNING;
                RUNNING:      if (bus.stop) state_nxt = PAUSED;
                default:      state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        run_en = (state == RUNNING);
    end

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_en),
        .clr   (bus.clear),
        .tick  (tick)
    );

    // out-of-range values fall into the wrap branch on the next tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seconds_q <= '0;
        end else if (bus.clear) begin
            seconds_q <= '0;
        end else if (tick) begin
            seconds_q <= (seconds_q >= SEC_MAX) ? '0 : seconds_q + SEC_W'(1);
        end
    end

    assign bus.seconds = seconds_q;
    assign bus.roll    = tick & (seconds_q == SEC_MAX);
    assign bus.running = run_en;

endmodule

// File: tb/tb_seconds_counter.sv
// tb/tb_seconds_counter.sv - randomized and directed checks of seconds_counter
module tb_seconds_counter;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   minutes;
    logic min_clr;

    seconds_counter_if bus_a ();
    seconds_counter_if bus_b ();

    seconds_counter #(.CLK_DIV(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    seconds_counter #(.CLK_DIV(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in for the downstream minutes counter, enabled by roll
    always @(posedge clk) begin
        if (min_clr) minutes <= 0;
        else if (bus_b.roll) minutes <= minutes + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_a(input bit s, input bit p, input bit c);
        bus_a.start = s; bus_a.stop = p; bus_a.clear = c;
        step(1);
        bus_a.start = 0; bus_a.stop = 0; bus_a.clear = 0;
    endtask

    task automatic test_reset();
        int n;
        #1;
        tests++; if (bus_a.seconds !== 6'd0) begin fails++; $display("FAIL reset_seconds: got %0d expected 0", bus_a.seconds); end
        tests++; if (bus_a.running !== 1'b0) begin fails++; $display("FAIL reset_running: got %0d expected 0", bus_a.running); end
        step(2);
        rst_n = 1;
        step(1);
        pulse_a(1, 0, 0);
        n = 0;
        while (bus_a.seconds !== 6'd17 && n < 200) begin
            step(1);
            n++;
        end
        tests++; if (n >= 200) begin fails++; $display("FAIL reach_17: got %0d expected 17", bus_a.seconds); end
        #2 rst_n = 0;
        #1;
        tests++; if (bus_a.seconds !== 6'd0) begin fails++; $display("FAIL async_reset_seconds: got %0d expected 0", bus_a.seconds); end
        tests++; if (bus_a.running !== 1'b0) begin fails++; $display("FAIL async_reset_running: got %0d expected 0", bus_a.running); end
        tests++; if (bus_a.roll !== 1'b0) begin fails++; $display("FAIL async_reset_roll: got %0d expected 0", bus_a.roll); end
        step(3);
        rst_n = 1;
        step(10);
        tests++; if (bus_a.seconds !== 6'd0 || bus_a.running !== 1'b0) begin fails++; $display("FAIL post_reset_idle: got sec=%0d run=%0d expected 0/0", bus_a.seconds, bus_a.running); end
    endtask

    task automatic test_basic_count();
        logic exp_roll;
        pulse_a(0, 0, 1);
        pulse_a(1, 0, 0);
        tests++; if (bus_a.running !== 1'b1) begin fails++; $display("FAIL start_latency: got %0d expected 1", bus_a.running); end
        for (int k = 1; k <= 244; k++) begin
            exp_roll = (k == 240);
            tests++; if (bus_a.roll !== exp_roll) begin fails++; $display("FAIL basic_roll_k%0d: got %0d expected %0d", k, bus_a.roll, exp_roll); end
            if (k == 5) begin
                tests++; if (bus_a.seconds !== 6'd1) begin fails++; $display("FAIL first_second: got %0d expected 1", bus_a.seconds); end
            end
            if (k == 237) begin
                tests++; if (bus_a.seconds !== 6'd59) begin fails++; $display("FAIL reach_59: got %0d expected 59", bus_a.seconds); end
            end
            if (k == 241) begin
                tests++; if (bus_a.seconds !== 6'd0) begin fails++; $display("FAIL wrap_0: got %0d expected 0", bus_a.seconds); end
            end
            step(1);
        end
    endtask

    task automatic test_pause_resume();
        pulse_a(0, 0, 1);
        pulse_a(1, 0, 0);
        step(42);
        tests++; if (bus_a.seconds !== 6'd10) begin fails++; $display("FAIL pre_stop: got %0d expected 10", bus_a.seconds); end
        pulse_a(0, 1, 0);
        tests++; if (bus_a.running !== 1'b0) begin fails++; $display("FAIL paused_running: got %0d expected 0", bus_a.running); end
        for (int k = 0; k < 50; k++) begin
            tests++; if (bus_a.seconds !== 6'd10) begin fails++; $display("FAIL paused_hold_%0d: got %0d expected 10", k, bus_a.seconds); end
            step(1);
        end
        pulse_a(1, 0, 0);
        tests++; if (bus_a.running !== 1'b1 || bus_a.seconds !== 6'd10) begin fails++; $display("FAIL resume_edge: got run=%0d sec=%0d expected 1/10", bus_a.running, bus_a.seconds); end
        step(1);
        tests++; if (bus_a.seconds !== 6'd11) begin fails++; $display("FAIL resume_phase: got %0d expected 11", bus_a.seconds); end
        step(3);
        tests++; if (bus_a.seconds !== 6'd11) begin fails++; $display("FAIL resume_hold11: got %0d expected 11", bus_a.seconds); end
        step(1);
        tests++; if (bus_a.seconds !== 6'd12) begin fails++; $display("FAIL resume_next: got %0d expected 12", bus_a.seconds); end
    endtask

    task automatic test_coincident();
        pulse_a(0, 0, 1);
        pulse_a(1, 0, 0);
        step(239);
        bus_a.stop = 1;
        #1;
        tests++; if (bus_a.roll !== 1'b1) begin fails++; $display("FAIL stop_tick_roll: got %0d expected 1", bus_a.roll); end
        step(1);
        bus_a.stop = 0;
        tests++; if (bus_a.seconds !== 6'd0 || bus_a.running !== 1'b0) begin fails++; $display("FAIL stop_tick_after: got sec=%0d run=%0d expected 0/0", bus_a.seconds, bus_a.running); end

        pulse_a(0, 0, 1);
        pulse_a(1, 0, 0);
        step(239);
        bus_a.clear = 1;
        #1;
        tests++; if (bus_a.roll !== 1'b0) begin fails++; $display("FAIL clear_tick_roll: got %0d expected 0", bus_a.roll); end
        step(1);
        bus_a.clear = 0;
        tests++; if (bus_a.seconds !== 6'd0 || bus_a.running !== 1'b0) begin fails++; $display("FAIL clear_tick_after: got sec=%0d run=%0d expected 0/0", bus_a.seconds, bus_a.running); end
        pulse_a(1, 0, 0);
        step(4);
        tests++; if (bus_a.seconds !== 6'd1) begin fails++; $display("FAIL clear_restart: got %0d expected 1", bus_a.seconds); end
    endtask

    task automatic test_priority();
        pulse_a(0, 0, 1);
        pulse_a(1, 1, 0);
        tests++; if (bus_a.running !== 1'b0) begin fails++; $display("FAIL idle_start_stop: got %0d expected 0", bus_a.running); end
        step(8);
        tests++; if (bus_a.seconds !== 6'd0) begin fails++; $display("FAIL idle_start_stop_sec: got %0d expected 0", bus_a.seconds); end
        pulse_a(1, 0, 0);
        step(9);
        tests++; if (bus_a.seconds !== 6'd2) begin fails++; $display("FAIL prio_precount: got %0d expected 2", bus_a.seconds); end
        pulse_a(1, 1, 1);
        tests++; if (bus_a.running !== 1'b0 || bus_a.seconds !== 6'd0) begin fails++; $display("FAIL all_three: got run=%0d sec=%0d expected 0/0", bus_a.running, bus_a.seconds); end
        step(8);
        tests++; if (bus_a.running !== 1'b0 || bus_a.seconds !== 6'd0) begin fails++; $display("FAIL all_three_idle: got run=%0d sec=%0d expected 0/0", bus_a.running, bus_a.seconds); end
    endtask

    // model: seconds and roll follow from the number of running cycles since the last clear
    task automatic test_random();
        int   run_cycles;
        bit   model_run;
        bit   s, p, c;
        logic exp_roll;
        logic [5:0] exp_sec;
        pulse_a(0, 0, 1);
        run_cycles = 0;
        model_run  = 0;
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(7) == 0);
            p = ($urandom_range(99) == 0);
            c = ($urandom_range(499) == 0);
            bus_a.start = s; bus_a.stop = p; bus_a.clear = c;
            #1;
            exp_sec  = 6'((run_cycles / 4) % 60);
            exp_roll = model_run && !c && (run_cycles % 4 == 3) && ((run_cycles / 4) % 60 == 59);
            tests++; if (bus_a.seconds !== exp_sec) begin fails++; $display("FAIL rand_seconds_%0d: got %0d expected %0d", i, bus_a.seconds, exp_sec); end
            tests++; if (bus_a.running !== model_run) begin fails++; $display("FAIL rand_running_%0d: got %0d expected %0d", i, bus_a.running, model_run); end
            tests++; if (bus_a.roll !== exp_roll) begin fails++; $display("FAIL rand_roll_%0d: got %0d expected %0d", i, bus_a.roll, exp_roll); end
            @(posedge clk);
            #1;
            if (c) begin
                run_cycles = 0;
                model_run  = 0;
            end else begin
                if (model_run) run_cycles++;
                if (model_run && p) model_run = 0;
                else if (!model_run && s && !p) model_run = 1;
            end
        end
        bus_a.start = 0; bus_a.stop = 0; bus_a.clear = 0;
    endtask

    task automatic test_minutes_integration();
        int rolls;
        min_clr = 1;
        bus_b.clear = 1;
        step(1);
        min_clr = 0;
        bus_b.clear = 0;
        bus_b.start = 1;
        step(1);
        bus_b.start = 0;
        rolls = 0;
        for (int k = 1; k <= 3600; k++) begin
            if (bus_b.roll === 1'b1) rolls++;
            step(1);
        end
        tests++; if (bus_b.seconds !== 6'd0) begin fails++; $display("FAIL hour_seconds: got %0d expected 0", bus_b.seconds); end
        tests++; if (rolls != 60) begin fails++; $display("FAIL hour_rolls: got %0d expected 60", rolls); end
        tests++; if (minutes != 60) begin fails++; $display("FAIL hour_minutes: got %0d expected 60", minutes); end
        tests++; if (bus_b.running !== 1'b1) begin fails++; $display("FAIL hour_running: got %0d expected 1", bus_b.running); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        min_clr = 1'b1;
        rst_n = 1'b0;
        bus_a.start = 0; bus_a.stop = 0; bus_a.clear = 0;
        bus_b.start = 0; bus_b.stop = 0; bus_b.clear = 0;
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_coincident();
        test_priority();
        test_random();
        test_minutes_integration();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
